// File: rtl/mux2x1_rr_arbiter_if.sv
// Handshake bundle for the two-source round-robin arbiter: two valid/ready
// inputs, one registered valid/ready output, plus select and busy status.
interface mux2x1_rr_arbiter_if #(
  parameter int unsigned WIDTH = 8
);
  logic [WIDTH-1:0] a0;
  logic             v0;
  logic             rdy0;
  logic [WIDTH-1:0] a1;
  logic             v1;
  logic             rdy1;
  logic [WIDTH-1:0] y;
  logic             yv;
  logic             yrdy;
  logic             s;
  logic             busy;

  modport master (
    output a0, v0, a1, v1, yrdy,
    input  rdy0, rdy1, y, yv, s, busy
  );

  modport slave (
    input  a0, v0, a1, v1, yrdy,
    output rdy0, rdy1, y, yv, s, busy
  );
endinterface

// File: rtl/mux2x1_rr_arbiter.sv
// Two-source round-robin arbiter with per-owner burst limit feeding one
// registered output stage; holds under downstream backpressure.
module mux2x1_rr_arbiter #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned BURST = 4
) (
  input logic                 clk,
  input logic                 rst,
  mux2x1_rr_arbiter_if.slave  bus
);
  localparam int unsigned CW = $clog2(BURST + 1);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  state_t           state;
  logic             last;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    cnt_nxt;
  logic             load;
  logic             pick_vld;
  logic             pick;
  logic [WIDTH-1:0] y_q;
  logic             yv_q;
  logic             s_q;
  logic             busy_q;

  // Output register is free when empty or being drained this cycle.
  assign load = ~yv_q | bus.yrdy;

  always_comb begin
    pick_vld = 1'b0;
    pick     = 1'b0;
    cnt_nxt  = '0;
    if (load) begin
      case (state)
        OWN0: begin
          if (bus.v0 && (cnt < CW'(BURST))) begin
            pick_vld = 1'b1;
            pick     = 1'b0;
            cnt_nxt  = cnt + CW'(1);
          end else if (bus.v1) begin
            pick_vld = 1'b1;
            pick     = 1'b1;
            cnt_nxt  = CW'(1);
          end else if (bus.v0) begin
            pick_vld = 1'b1;
            pick     = 1'b0;
            cnt_nxt  = CW'(1);
          end
        end
        OWN1: begin
          if (bus.v1 && (cnt < CW'(BURST))) begin
            pick_vld = 1'b1;
            pick     = 1'b1;
            cnt_nxt  = cnt + CW'(1);
          end else if (bus.v0) begin
            pick_vld = 1'b1;
            pick     = 1'b0;
            cnt_nxt  = CW'(1);
          end else if (bus.v1) begin
            pick_vld = 1'b1;
            pick     = 1'b1;
            cnt_nxt  = CW'(1);
          end
        end
        default: begin
          if (bus.v0 && bus.v1) begin
            pick_vld = 1'b1;
            pick     = ~last;
            cnt_nxt  = CW'(1);
          end else if (bus.v0 || bus.v1) begin
            pick_vld = 1'b1;
            pick     = bus.v1;
            cnt_nxt  = CW'(1);
          end
        end
      endcase
    end
  end

  // Readies are suppressed during reset so nothing is consumed then.
  assign bus.rdy0 = pick_vld & ~pick & ~rst;
  assign bus.rdy1 = pick_vld &  pick & ~rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      last   <= 1'b1;
      cnt    <= '0;
      y_q    <= '0;
      yv_q   <= 1'b0;
      s_q    <= 1'b0;
      busy_q <= 1'b0;
    end else if (load) begin
      if (pick_vld) begin
        y_q    <= pick ? bus.a1 : bus.a0;
        yv_q   <= 1'b1;
        s_q    <= pick;
        last   <= pick;
        state  <= pick ? OWN1 : OWN0;
        cnt    <= cnt_nxt;
        busy_q <= 1'b1;
      end else begin
        yv_q   <= 1'b0;
        state  <= IDLE;
        cnt    <= '0;
        busy_q <= 1'b0;
      end
    end
  end

  assign bus.y    = y_q;
  assign bus.yv   = yv_q;
  assign bus.s    = s_q;
  assign bus.busy = busy_q;
endmodule

// File: doc/mux2x1_rr_arbiter.md
# mux2x1_rr_arbiter

Two-requester round-robin arbiter that shares one 2:1 select path between two valid/ready sources and drives one registered valid/ready output. Each source gets bounded bursts. The block owns the mux select: it decides each cycle which source, if any, is forwarded, applies per-source burst limits, and holds the output under downstream backpressure. It sits between two producers and a single shared consumer.

## Interface
- WIDTH, 8, data width of both inputs and the output.
- BURST, 4, maximum consecutive transfers granted to one source while the other is waiting; must be 1 or more. With BURST=1 the block is pure alternating round-robin.
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- a0  input  WIDTH  data from source 0.
- v0  input  1  source 0 valid.
- rdy0  output  1  source 0 ready; a transfer occurs when v0 and rdy0 are both high.
- a1  input  WIDTH  data from source 1.
- v1  input  1  source 1 valid.
- rdy1  output  1  source 1 ready.
- y  output  WIDTH  registered output data.
- yv  output  1  output valid.
- yrdy  input  1  downstream ready.
- s  output  1  registered select: the source of the word currently in y.
- busy  output  1  high when state is OWN0 or OWN1.

## Operation
- Registered state:
  - FSM state: IDLE, OWN0 or OWN1.
  - last: source of the most recent transfer.
  - cnt: transfers in the current burst; width is clog2(BURST+1).
- Load condition: load = ~yv | yrdy, meaning the output register is empty or is draining this cycle.
- Pick logic is combinational and is evaluated only when load is high. Let o be the current owner and x = ~o.
  - keep: the state is OWNo, v_o is high and cnt < BURST. The pick is o, and cnt becomes cnt+1.
  - Otherwise, when the state is OWNo:
    - if v_x is high, pick x, with cnt = 1;
    - else if v_o is high, pick o as a new burst, with cnt = 1;
    - else there is no pick.
  - In IDLE:
    - if both sources are valid, pick ~last;
    - else pick the single valid source;
    - else there is no pick. In every IDLE pick, cnt = 1.
- On a pick p:
  - rdy_p = 1 and the other ready is 0;
  - y <= a_p, yv <= 1, s <= p, last <= p, state <= OWNp.
- On load with no pick: yv <= 0, state <= IDLE, cnt <= 0. y and s hold.
- When load is low: rdy0 = rdy1 = 0, and y, yv, s, state and cnt all hold.
- rdy0 and rdy1 are never high together.
- rdy may depend combinationally on v0, v1 and yrdy. It never depends on itself.
- Reset values: state IDLE, last = 1 (so source 0 wins the first tie), cnt = 0, y = 0, yv = 0, s = 0, busy = 0, rdy0 = rdy1 = 0 while rst is high.

## Timing
- Latency: an input accepted at edge N appears on y with yv high after edge N, which is 1 cycle.
- Throughput: 1 word per cycle while yrdy stays high. No bubble on an owner switch or on a burst restart.
- Backpressure: while yv=1 and yrdy=0, y, s and yv stay stable and no input is accepted.
- Burst boundary: after BURST transfers from o with v_x high, the next load picks x.
- If v_x is low at the burst boundary, o continues with a fresh burst.
- If the owner drops valid mid-burst, the next load re-arbitrates. The burst count is not preserved.
- Reset mid-burst: on the next cycle the state is IDLE, yv=0, and any data in y is discarded.
- Reset has priority over every simultaneous event.

## Test plan
Test parameters: WIDTH=8, BURST=4.

1. Reset: assert rst for 2 cycles with v0=v1=1 -> yv=0, y=0x00, s=0, busy=0, rdy0=rdy1=0 throughout.
2. Single source: v0=1 with a0 = 0x10..0x15 on consecutive accepts, v1=0, yrdy=1 -> y shows 0x10..0x15 on 6 consecutive cycles with s=0; rdy0 stays high, including across the burst restart after 4.
3. Contention: v0=v1=1 continuously, a0 = 0xA0.., a1 = 0xB0.., yrdy=1 -> output sequence A0 A1 A2 A3 B0 B1 B2 B3 A4 A5…, with s toggling every 4 cycles.
4. Backpressure: while streaming, yrdy=0 for 3 cycles -> y and yv=1 hold and rdy0=rdy1=0; after yrdy returns, the next word follows with nothing lost or duplicated.
5. Early release: source 0 owns, v0 drops after 2 transfers while v1=1 -> the next load picks source 1 (s=1, cnt=1); if v0 is later re-asserted, it is served after source 1's burst.
6. Reset mid-burst: rst pulses after 3 transfers from source 1 -> next cycle yv=0 and state IDLE; with both valid, the first word after reset comes from source 0.
